pbp_train_sched: RTL and testbench
==================================

Name: pbp_train_sched

Overview:
Training scheduler for the perceptron branch predictor table. It accepts resolved-branch events from EX/MEM, filters them by the perceptron training rule, and buffers the ones that need training in a small FIFO. It sequences read-modify-write updates over the table's second port and performs the zero-initialisation sweep after reset or on request. The perceptron table and its weight-update adders are outside this block; this block only drives index, enable and update-control signals.

Parameters:
W_BITS, 8, weight and y_out width (two's complement)
HIST_LEN, 12, global history length
B_SETS, 5, table index bits; table has 2^B_SETS entries
THETA, 37, training threshold on |y_out|
FIFO_DEPTH, 4, pending-update FIFO entries; must be a power of 2, >=2

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
evt_valid  in  1  resolved conditional branch present (opcode op_br in EX/MEM)
evt_ready  out  1  event accepted this cycle when valid&&ready
evt_pc  in  32  branch PC
evt_taken  in  1  actual outcome
evt_pred  in  1  predicted outcome
evt_y  in  W_BITS  perceptron sum captured at prediction
evt_hist  in  HIST_LEN  GHR snapshot used for the prediction
init_req  in  1  pulse: re-zero the whole table
pt_idx  out  B_SETS  table index for read/write port 2
pt_rd_en  out  1  read phase of an update
pt_wr_en  out  1  table write strobe
pt_wr_zero  out  1  write all-zero weights (init sweep)
upd_taken  out  1  outcome for the weight-update adders
upd_hist  out  HIST_LEN  history for the weight-update adders
init_done  out  1  high after first sweep completes; sticky until rst
busy  out  1  state!=IDLE or FIFO non-empty

Behaviour:
- Reset (rst=0 at edge): state=INIT, sweep counter=0, FIFO emptied, init_done=0. All outputs are 0 the cycle after reset except that INIT drives pt_wr_en/pt_wr_zero.
- States: INIT, IDLE, RD, WR.
- INIT: each cycle pt_wr_en=1, pt_wr_zero=1, pt_idx=counter, and the counter increments. After the write at index 2^B_SETS-1, go to IDLE and set init_done=1. evt_ready=0 throughout INIT.
- evt_ready = (state!=INIT) && !fifo_full. Full is evaluated before the same-cycle pop, so there is no enqueue on a full FIFO.
- Training filter on accept: train = (evt_pred!=evt_taken) || |evt_y|<=THETA.
  - |evt_y| is computed at W_BITS+1 width, so -2^(W_BITS-1) yields 2^(W_BITS-1), which is not <=THETA.
  - Accepted events with train=0 are dropped with no table access.
  - Entries with train=1 are stored as {idx=evt_pc[B_SETS+1:2], taken, hist}.
- IDLE: if the FIFO is non-empty, go to RD.
- RD (1 cycle): pt_rd_en=1, pt_idx=head.idx. Next state is WR.
- WR (1 cycle): pt_wr_en=1, pt_idx=head.idx (held from RD), upd_taken=head.taken, upd_hist=head.hist, and the head is popped. Next state is RD if the FIFO is still non-empty after the pop, else IDLE.
- Throughput: one update per 2 cycles. Updates are written in acceptance order.
- Outputs when not in RD/WR/INIT: pt_rd_en=pt_wr_en=pt_wr_zero=0; pt_idx, upd_taken and upd_hist are 0.
- init_req:
  - In IDLE or RD: enter INIT next cycle. The FIFO is flushed and the in-flight RD is abandoned with no write.
  - In WR: complete the write, then enter INIT with the FIFO flushed.
  - In INIT: restart the counter at 0.
  - init_done remains 1 during a requested sweep.
- An event accepted in the same cycle as init_req is discarded by the flush.
- rst low in any state: reset values apply at the next edge; a partial write pattern is acceptable because the sweep rewrites every entry.

Decomposition:
- rv32i_types gains a pbp_upd_t packed struct {idx, taken, hist} and localparam PBP_THETA.
- One sub-module: pbp_upd_fifo, a parameterised synchronous FIFO (push, pop, full, empty, head; pointer wrap at FIFO_DEPTH).
- The FSM, filter and sweep counter live in pbp_train_sched.

Test Plan:
1. Release rst with B_SETS=5 -> 32 consecutive cycles of pt_wr_en=pt_wr_zero=1 with pt_idx 0..31; evt_ready=0; init_done=1 on the following cycle; busy=0.
2. Event pc=0x00000044, taken=1, pred=0, y=0x05, hist=0xA5A, accepted at cycle N -> RD at N+1 with pt_idx=17, WR at N+2 with pt_idx=17, upd_taken=1, upd_hist=0xA5A.
3. Correctly predicted events, each sent alone:
   - y=0x50 -> no table access.
   - y=0x25 (37) -> trained.
   - y=0xDB (-37) -> trained.
   - y=0x80 (-128) -> not trained.
4. evt_valid held with 8 mispredicted events on distinct PCs, FIFO_DEPTH=4 -> evt_ready deasserts while full; all 8 WR strobes occur in order, spaced 2 cycles apart; busy falls after the last WR.
5. init_req asserted during WR of the first of 3 queued updates -> that WR completes, the other 2 are never written, and a 32-cycle sweep follows.
6. rst driven low during RD -> next cycle state=INIT with pt_idx=0 and the FIFO empty; the dropped update never produces a write.

Source files
------------

// File: rtl/pbp_train_sched_pkg.sv
// Shared types for the perceptron training scheduler: queued update record,
// FSM state encoding and default geometry.
package pbp_train_sched_pkg;

    localparam int PBP_W_BITS     = 8;
    localparam int PBP_HIST_LEN   = 12;
    localparam int PBP_B_SETS     = 5;
    localparam int PBP_THETA      = 37;
    localparam int PBP_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [PBP_B_SETS-1:0]   idx;
        logic                    taken;
        logic [PBP_HIST_LEN-1:0] hist;
    } pbp_upd_t;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RD   = 2'd2,
        ST_WR   = 2'd3
    } pbp_state_e;

endpackage

// File: rtl/pbp_train_sched_if.sv
// Resolved-branch event channel from EX/MEM into the training scheduler.
interface pbp_train_sched_if
    import pbp_train_sched_pkg::*;
#(
    parameter int W_BITS   = PBP_W_BITS,
    parameter int HIST_LEN = PBP_HIST_LEN
);
    logic                evt_valid;
    logic                evt_ready;
    logic [31:0]         evt_pc;
    logic                evt_taken;
    logic                evt_pred;
    logic [W_BITS-1:0]   evt_y;
    logic [HIST_LEN-1:0] evt_hist;

    modport master (
        output evt_valid, evt_pc, evt_taken, evt_pred, evt_y, evt_hist,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_pc, evt_taken, evt_pred, evt_y, evt_hist,
        output evt_ready
    );
endinterface

// File: rtl/pbp_train_sched_upd_fifo.sv
// Pending-update FIFO; DEPTH must be a power of two so the pointers wrap freely.
module pbp_upd_fifo
    import pbp_train_sched_pkg::*;
#(
    parameter int DEPTH = PBP_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  pbp_upd_t                 din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output pbp_upd_t                 head
);
    localparam int AW = $clog2(DEPTH);

    pbp_upd_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push_d;
    logic            do_pop_d;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == {(AW+1){1'b0}});
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Qualify requests so a full/empty FIFO is never corrupted.
    always_comb begin
        do_push_d = push && !full;
        do_pop_d  = pop && !empty;
    end

    // Pointer and occupancy tracking; flush drops every entry at once.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_d) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop_d)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push_d, do_pop_d})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (do_push_d) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/pbp_train_sched.sv
// Perceptron training scheduler: filters resolved branches, queues the ones that
// need training and sequences RD/WR updates plus the zero-init sweep on port 2.
module pbp_train_sched
    import pbp_train_sched_pkg::*;
#(
    parameter int W_BITS     = PBP_W_BITS,
    parameter int HIST_LEN   = PBP_HIST_LEN,
    parameter int B_SETS     = PBP_B_SETS,
    parameter int THETA      = PBP_THETA,
    parameter int FIFO_DEPTH = PBP_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    pbp_train_sched_if.slave    evt,
    input  logic                init_req,
    output logic [B_SETS-1:0]   pt_idx,
    output logic                pt_rd_en,
    output logic                pt_wr_en,
    output logic                pt_wr_zero,
    output logic                upd_taken,
    output logic [HIST_LEN-1:0] upd_hist,
    output logic                init_done,
    output logic                busy
);
    localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [W_BITS:0] THETA_V = (W_BITS+1)'(THETA);

    pbp_state_e        state_q;
    logic [B_SETS-1:0] sweep_q;
    logic              init_done_q;

    logic [W_BITS:0]   y_ext_d;
    logic [W_BITS:0]   y_abs_d;
    logic              train_d;
    logic              push_d;
    logic              more_d;
    pbp_upd_t          entry_d;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    pbp_upd_t          fifo_head;
    logic              unused_pc_bits;

    assign unused_pc_bits = ^{evt.evt_pc[31:B_SETS+2], evt.evt_pc[1:0]};
    assign evt.evt_ready  = (state_q != ST_INIT) && !fifo_full;
    assign busy           = (state_q != ST_IDLE) || !fifo_empty;
    assign init_done      = init_done_q;

    // Training filter; |y| is taken one bit wider so the most negative sum is not folded.
    always_comb begin
        y_ext_d = {evt.evt_y[W_BITS-1], evt.evt_y};
        y_abs_d = y_ext_d[W_BITS] ? (~y_ext_d + {{W_BITS{1'b0}}, 1'b1}) : y_ext_d;
        train_d = (evt.evt_pred != evt.evt_taken) || (y_abs_d <= THETA_V);
        push_d  = evt.evt_valid && evt.evt_ready && train_d && !init_req;
        more_d  = (fifo_count > CW'(1)) || push_d;
        entry_d = '{idx: evt.evt_pc[B_SETS+1:2], taken: evt.evt_taken, hist: evt.evt_hist};
    end

    pbp_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (init_req),
        .push  (push_d),
        .pop   (state_q == ST_WR),
        .din   (entry_d),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    // Sequencer: sweep, then alternate RD/WR while updates are pending.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            sweep_q     <= {B_SETS{1'b0}};
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_req) begin
                        sweep_q <= {B_SETS{1'b0}};
                    end else if (sweep_q == {B_SETS{1'b1}}) begin
                        sweep_q     <= {B_SETS{1'b0}};
                        state_q     <= ST_IDLE;
                        init_done_q <= 1'b1;
                    end else begin
                        sweep_q <= sweep_q + B_SETS'(1);
                    end
                end
                ST_IDLE: begin
                    if (init_req)                   state_q <= ST_INIT;
                    else if (!fifo_empty || push_d) state_q <= ST_RD;
                    else                            state_q <= ST_IDLE;
                end
                ST_RD: begin
                    state_q <= init_req ? ST_INIT : ST_WR;
                end
                ST_WR: begin
                    if (init_req)    state_q <= ST_INIT;
                    else if (more_d) state_q <= ST_RD;
                    else             state_q <= ST_IDLE;
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // Port-2 drive decoded from the state and FIFO head flops.
    always_comb begin
        pt_idx     = {B_SETS{1'b0}};
        pt_rd_en   = 1'b0;
        pt_wr_en   = 1'b0;
        pt_wr_zero = 1'b0;
        upd_taken  = 1'b0;
        upd_hist   = {HIST_LEN{1'b0}};
        case (state_q)
            ST_INIT: begin
                pt_idx     = sweep_q;
                pt_wr_en   = 1'b1;
                pt_wr_zero = 1'b1;
            end
            ST_RD: begin
                pt_idx   = fifo_head.idx;
                pt_rd_en = 1'b1;
            end
            ST_WR: begin
                pt_idx    = fifo_head.idx;
                pt_wr_en  = 1'b1;
                upd_taken = fifo_head.taken;
                upd_hist  = fifo_head.hist;
            end
            default: begin
                pt_idx = {B_SETS{1'b0}};
            end
        endcase
    end
endmodule

// File: tb/tb_pbp_train_sched.sv
// Bench for pbp_train_sched: directed scenarios plus random traffic, all checked
// against a queue-based model of which updates must be written and when sweeps run.
module tb_pbp_train_sched;
    typedef struct {
        logic [4:0]  idx;
        logic        taken;
        logic [11:0] hist;
    } upd_t;

    logic        clk;
    logic        rst;
    logic        init_req;
    logic [4:0]  pt_idx;
    logic        pt_rd_en;
    logic        pt_wr_en;
    logic        pt_wr_zero;
    logic        upd_taken;
    logic [11:0] upd_hist;
    logic        init_done;
    logic        busy;

    pbp_train_sched_if #(.W_BITS(8), .HIST_LEN(12)) evt_if ();

    pbp_train_sched dut (
        .clk        (clk),
        .rst        (rst),
        .evt        (evt_if),
        .init_req   (init_req),
        .pt_idx     (pt_idx),
        .pt_rd_en   (pt_rd_en),
        .pt_wr_en   (pt_wr_en),
        .pt_wr_zero (pt_wr_zero),
        .upd_taken  (upd_taken),
        .upd_hist   (upd_hist),
        .init_done  (init_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    bit   model_ok = 1'b0;
    int   sweep_left = 0;
    bit   init_done_exp = 1'b0;
    upd_t q[$];
    int   stall = 0;
    bit   prev_rd = 1'b0;
    logic [4:0] prev_idx = 5'd0;
    int   wr_cycles[$];
    int   last_rd_cyc = -1;
    int   zero_cnt = 0;
    logic [4:0]  last_wr_idx = 5'd0;
    logic        last_wr_taken = 1'b0;
    logic [11:0] last_wr_hist = 12'd0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: observe at negedge against the model, then drive the next inputs.
    task automatic step(input logic v, input logic [31:0] pc, input logic tk, input logic pr,
                        input logic [7:0] y, input logic [11:0] h, input logic ireq,
                        input logic rstn, output logic acc);
        logic exp_ready;
        int   yi;
        int   mag;
        upd_t e;
        @(negedge clk);
        cyc++;
        exp_ready = (sweep_left == 0) && (q.size() < 4);
        if (pt_wr_zero === 1'b1) zero_cnt++;
        if (model_ok) begin
            check_eq("evt_ready", evt_if.evt_ready, exp_ready);
            check_eq("init_done", init_done, init_done_exp);
            check_eq("busy", busy, (sweep_left > 0) || (q.size() > 0));
            if (sweep_left > 0) begin
                check_eq("sweep_ctl", {pt_rd_en, pt_wr_en, pt_wr_zero}, 3'b011);
                check_eq("sweep_idx", pt_idx, 32 - sweep_left);
            end else begin
                check_eq("wr_zero", pt_wr_zero, 1'b0);
                check_eq("rd_wr_excl", pt_rd_en && pt_wr_en, 1'b0);
                if (pt_wr_en) begin
                    check_eq("wr_pending", q.size() > 0, 1'b1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check_eq("wr_idx", pt_idx, e.idx);
                        check_eq("wr_taken", upd_taken, e.taken);
                        check_eq("wr_hist", upd_hist, e.hist);
                    end
                    check_eq("wr_after_rd", {prev_rd, prev_idx}, {1'b1, pt_idx});
                    wr_cycles.push_back(cyc);
                    last_wr_idx = pt_idx;
                    last_wr_taken = upd_taken;
                    last_wr_hist = upd_hist;
                    stall = 0;
                end else if (pt_rd_en) begin
                    check_eq("rd_pending", q.size() > 0, 1'b1);
                    if (q.size() > 0) check_eq("rd_idx", pt_idx, q[0].idx);
                    last_rd_cyc = cyc;
                    stall++;
                end else begin
                    check_eq("idle_outs", {pt_idx, upd_taken, upd_hist}, 32'd0);
                    if (q.size() > 0) stall++;
                end
                check_eq("latency", stall <= 1, 1'b1);
            end
        end
        prev_rd  = pt_rd_en;
        prev_idx = pt_idx;

        acc = model_ok && rstn && v && exp_ready;
        evt_if.evt_valid = v;
        evt_if.evt_pc    = pc;
        evt_if.evt_taken = tk;
        evt_if.evt_pred  = pr;
        evt_if.evt_y     = y;
        evt_if.evt_hist  = h;
        init_req = ireq;
        rst      = rstn;

        yi  = int'($signed(y));
        mag = (yi < 0) ? -yi : yi;
        if (!rstn) begin
            sweep_left = 32;
            q.delete();
            init_done_exp = 1'b0;
            stall = 0;
            model_ok = 1'b1;
        end else if (ireq) begin
            sweep_left = 32;
            q.delete();
            stall = 0;
        end else begin
            if (sweep_left > 0) begin
                sweep_left--;
                if (sweep_left == 0) init_done_exp = 1'b1;
            end
            if (acc && ((tk != pr) || (mag <= 37))) begin
                e.idx   = pc[6:2];
                e.taken = tk;
                e.hist  = h;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        logic a;
        repeat (n) step(1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 12'd0, 1'b0, 1'b1, a);
    endtask

    logic        acc;
    int          k;
    int          n_acc;
    int          guard;
    bit          saw_block;
    logic [7:0]  ys [4];
    int          exp_w [4];
    logic [7:0]  sp_y [7];

    initial begin
        rst = 1'b0;
        init_req = 1'b0;
        evt_if.evt_valid = 1'b0;
        evt_if.evt_pc = 32'd0;
        evt_if.evt_taken = 1'b0;
        evt_if.evt_pred = 1'b0;
        evt_if.evt_y = 8'd0;
        evt_if.evt_hist = 12'd0;

        // Reset release and the power-on sweep.
        repeat (3) step(1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 12'd0, 1'b0, 1'b0, acc);
        zero_cnt = 0;
        idle(40);
        check_eq("t1_sweep_len", zero_cnt, 32);
        check_eq("t1_init_done", init_done, 1'b1);

        // Single mispredicted event: RD then WR at index 17.
        wr_cycles.delete();
        step(1'b1, 32'h0000_0044, 1'b1, 1'b0, 8'h05, 12'hA5A, 1'b0, 1'b1, acc);
        k = cyc;
        check_eq("t2_acc", acc, 1'b1);
        idle(4);
        check_eq("t2_rd_cyc", last_rd_cyc - k, 1);
        check_eq("t2_wr_cnt", wr_cycles.size(), 1);
        if (wr_cycles.size() == 1) check_eq("t2_wr_cyc", wr_cycles[0] - k, 2);
        check_eq("t2_wr_idx", last_wr_idx, 5'd17);
        check_eq("t2_wr_taken", last_wr_taken, 1'b1);
        check_eq("t2_wr_hist", last_wr_hist, 12'hA5A);

        // Correct predictions around the threshold.
        ys = '{8'h50, 8'h25, 8'hDB, 8'h80};
        exp_w = '{0, 1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            wr_cycles.delete();
            step(1'b1, 32'h0000_0080 + 32'(i * 4), 1'b1, 1'b1, ys[i], 12'h3C3, 1'b0, 1'b1, acc);
            idle(4);
            check_eq("t3_writes", wr_cycles.size(), exp_w[i]);
        end

        // Back-pressure with 8 queued mispredictions.
        wr_cycles.delete();
        n_acc = 0;
        guard = 0;
        saw_block = 1'b0;
        while (n_acc < 8 && guard < 100) begin
            step(1'b1, 32'h0000_0100 + 32'(n_acc * 4), n_acc[0], ~n_acc[0], 8'h10,
                 12'(n_acc * 37), 1'b0, 1'b1, acc);
            if (acc) n_acc++;
            else if (evt_if.evt_ready === 1'b0) saw_block = 1'b1;
            guard++;
        end
        check_eq("t4_accepted", n_acc, 8);
        check_eq("t4_blocked", saw_block, 1'b1);
        idle(25);
        check_eq("t4_writes", wr_cycles.size(), 8);
        if (wr_cycles.size() == 8)
            for (int i = 1; i < 8; i++) check_eq("t4_spacing", wr_cycles[i] - wr_cycles[i-1], 2);
        check_eq("t4_busy_end", busy, 1'b0);

        // init_req in the WR of the first of three queued updates.
        wr_cycles.delete();
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h0000_0200 + 32'(i * 4), 1'b0, 1'b1, 8'h01, 12'h111, 1'b0, 1'b1, acc);
        zero_cnt = 0;
        step(1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 12'd0, 1'b1, 1'b1, acc);
        idle(40);
        check_eq("t5_writes", wr_cycles.size(), 2);
        check_eq("t5_sweep_len", zero_cnt, 32);

        // rst low during RD drops the pending update.
        wr_cycles.delete();
        step(1'b1, 32'h0000_0300, 1'b1, 1'b0, 8'h00, 12'h222, 1'b0, 1'b1, acc);
        k = cyc;
        step(1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 12'd0, 1'b0, 1'b0, acc);
        check_eq("t6_rd_seen", last_rd_cyc - k, 1);
        idle(40);
        check_eq("t6_writes", wr_cycles.size(), 0);

        // Random traffic with occasional init requests and resets.
        sp_y = '{8'h25, 8'hDB, 8'h26, 8'hDA, 8'h80, 8'h7F, 8'h00};
        for (int i = 0; i < 1500; i++) begin
            logic        v;
            logic        tk;
            logic        pr;
            logic [7:0]  y;
            v  = ($urandom_range(0, 99) < 60);
            tk = 1'($urandom_range(0, 1));
            pr = ($urandom_range(0, 99) < 60) ? tk : ~tk;
            y  = ($urandom_range(0, 3) == 0) ? sp_y[$urandom_range(0, 6)] : 8'($urandom);
            step(v, $urandom, tk, pr, y, 12'($urandom), ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 499) != 0), acc);
        end
        idle(40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
